// File: rtl/clp_update_scheduler.sv
// Round-robin scheduler feeding two BCD readouts to a shared LCD driver, with a rate-limiting HOLD.
// Optional macro CLP_BLANK_LEADING_ZERO_EN: a tens digit of 0 is shown as a space.
module clp_update_scheduler #(
    parameter int unsigned HOLD_CYCLES = 1000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        req_a,
    input  logic [11:0] bcd_a,
    output logic        gnt_a,
    input  logic        req_b,
    input  logic [11:0] bcd_b,
    output logic        gnt_b,
    output logic        upd_req,
    input  logic        upd_ack,
    output logic [7:0]  d10_1,
    output logic [7:0]  d1_1,
    output logic [7:0]  d10ths_1,
    output logic [7:0]  d10_2,
    output logic [7:0]  d1_2,
    output logic [7:0]  d10ths_2,
    output logic        busy,
    output logic        bcd_err
);
    typedef enum logic [1:0] {IDLE, LOAD, REQ, HOLD} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [23:0] LINE_RST  = 24'h303030;

    state_t      state_q, state_d;
    logic        gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic        sel_b_q, sel_b_d;
    logic        prio_b_q, prio_b_d;
    logic        err_q, err_d;
    logic [11:0] cap_q, cap_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] line1_q, line1_d, line2_q, line2_d;
    logic [23:0] conv;
    logic        win_b, nib_bad;

    function automatic logic [7:0] dig(input logic [3:0] n);
        return (n > 4'd9) ? 8'h2D : {4'h3, n};
    endfunction

    function automatic logic [7:0] tens(input logic [3:0] n);
`ifdef CLP_BLANK_LEADING_ZERO_EN
        if (n == 4'd0) return 8'h20;
`endif
        return dig(n);
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        sel_b_d  = sel_b_q;
        prio_b_d = prio_b_q;
        err_d    = err_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        line1_d  = line1_q;
        line2_d  = line2_q;
        // B wins only when alone, or when both request and it is B's turn
        win_b    = req_b && (!req_a || prio_b_q);
        conv     = {tens(cap_q[11:8]), dig(cap_q[7:4]), dig(cap_q[3:0])};
        nib_bad  = (cap_q[11:8] > 4'd9) || (cap_q[7:4] > 4'd9) || (cap_q[3:0] > 4'd9);
        case (state_q)
            IDLE: if (req_a || req_b) begin
                state_d  = LOAD;
                gnt_a_d  = !win_b;
                gnt_b_d  = win_b;
                sel_b_d  = win_b;
                prio_b_d = !win_b;
                cap_d    = win_b ? bcd_b : bcd_a;
            end
            LOAD: begin
                if (sel_b_q) line2_d = conv;
                else         line1_d = conv;
                if (nib_bad) err_d = 1'b1;
                state_d = REQ;
            end
            REQ: if (upd_ack) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (cnt_q == HOLD_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            sel_b_q  <= 1'b0;
            prio_b_q <= 1'b0;
            err_q    <= 1'b0;
            cap_q    <= '0;
            cnt_q    <= '0;
            line1_q  <= LINE_RST;
            line2_q  <= LINE_RST;
        end else begin
            state_q  <= state_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            sel_b_q  <= sel_b_d;
            prio_b_q <= prio_b_d;
            err_q    <= err_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            line1_q  <= line1_d;
            line2_q  <= line2_d;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign upd_req  = (state_q == REQ);
    assign busy     = (state_q != IDLE);
    assign bcd_err  = err_q;
    assign {d10_1, d1_1, d10ths_1} = line1_q;
    assign {d10_2, d1_2, d10ths_2} = line2_q;
endmodule

// File: doc/clp_update_scheduler.md
CLP_UPDATE_SCHEDULER -- requirements
Module: clp_update_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, SHALL set the minimum cycles between completed driver updates; legal range 1..65535.
REQ-002 CLK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 RSTN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_a  input  1  SHALL be requester A's level request to update LCD line 1.
REQ-005 bcd_a  input  12  SHALL be requester A's value: [11:8] tens, [7:4] units, [3:0] tenths, BCD.
REQ-006 gnt_a  output  1  SHALL be a one-cycle pulse marking the cycle bcd_a was captured.
REQ-007 req_b / bcd_b / gnt_b SHALL be identical to REQ-004..006 for LCD line 2.
REQ-008 upd_req  output  1  SHALL be the update request to the LCD driver.
REQ-009 upd_ack  input  1  SHALL be the driver's acknowledge; the update is accepted when it is high while upd_req is high.
REQ-010 d10_1, d1_1, d10ths_1, d10_2, d1_2, d10ths_2  output  8 each  SHALL be the registered ASCII digit bytes for lines 1 and 2.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 bcd_err  output  1  SHALL be a sticky flag set when any captured nibble exceeds 9.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, REQ and HOLD.
REQ-014 IDLE: with req_a or req_b high at an edge, the block SHALL move to LOAD, pulse the winner's gnt for the next cycle, and capture the winner's bcd in that same edge.
REQ-015 Arbitration SHALL be round-robin: on a simultaneous request the side not granted last wins; the first grant after reset goes to A.
REQ-016 LOAD: in one cycle the block SHALL write the converted bytes into the winner's line registers (A->line 1, B->line 2), leave the other line unchanged, and move to REQ.
REQ-017 Conversion SHALL map each nibble 0..9 to 0x30+nibble and each nibble 10..15 to 0x2D ('-'), setting bcd_err.
REQ-018 REQ: upd_req SHALL be high for every cycle in REQ; when upd_ack is sampled high the block SHALL move to HOLD and drop upd_req at that edge.
REQ-019 upd_ack outside REQ SHALL be ignored.
REQ-020 HOLD: the block SHALL stay exactly HOLD_CYCLES cycles, then return to IDLE; requests arriving meanwhile SHALL stay pending and are not granted.
REQ-021 Line registers SHALL change only in LOAD, so the driver sees stable bytes from upd_req rise until after ack.
REQ-022 Latency: a request sampled in IDLE at edge n SHALL give gnt high in cycle n..n+1, bytes updated and upd_req high from edge n+1.
REQ-023 A requester that deasserts before grant SHALL receive no grant; a requester still high after its grant SHALL be re-arbitrated normally.

Reset
REQ-024 On RSTN low, immediately: state IDLE, upd_req 0, gnt_a/gnt_b 0, busy 0, bcd_err 0, HOLD counter 0, round-robin pointer favouring A, all six digit bytes 0x30.
REQ-025 Reset asserted mid-operation (any state) SHALL abandon the update with no further upd_req; operation restarts from IDLE on the first edge after release.

Configuration
REQ-026 Macro CLP_BLANK_LEADING_ZERO_EN: when defined, a tens nibble of 0 SHALL convert to 0x20 (space); units and tenths are unaffected.
REQ-027 Without CLP_BLANK_LEADING_ZERO_EN, a tens nibble of 0 SHALL convert to 0x30.

Verification
REQ-028 Reset, then req_a=1 with bcd_a=0x123 -> gnt_a one cycle; d10_1/d1_1/d10ths_1 = 0x31/0x32/0x33; line 2 remains 0x30; upd_req high until ack.
REQ-029 req_a and req_b rise in the same cycle, held high -> grant A first, B after HOLD_CYCLES, then A again (alternating).
REQ-030 bcd_b=0x9A5 -> d10_2=0x39, d1_2=0x2D, d10ths_2=0x35, bcd_err=1, held until reset.
REQ-031 upd_ack delayed 7 cycles -> upd_req high for 7 cycles, bytes stable; spurious upd_ack in IDLE -> no state change.
REQ-032 RSTN low during REQ -> upd_req 0 asynchronously, all bytes 0x30, busy 0.
REQ-033 bcd_a=0x045 built with and without CLP_BLANK_LEADING_ZERO_EN -> d10_1=0x20 with the macro, 0x30 without.
